// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive path.
//   UART_BIT_PERIOD : default clocks per bit (12 MHz clock, 9600 baud); the
//                     CPU core and the TX block use the same constant.
//   rx_state_e      : encoding of the receive FSM states.
package uart_rx_fifo_pkg;

   localparam int unsigned UART_BIT_PERIOD = 1250;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk, rst : clock and synchronous active-high reset (control state only)
//   push     : write din when there is room, or when a pop frees a slot in
//              the same cycle
//   pop      : remove the head entry; ignored while empty
//   din/dout : write data / head-of-FIFO data (valid while !empty)
//   count    : number of stored entries, 0..DEPTH
//   full     : count == DEPTH
//   empty    : count == 0
module sync_fifo #(
   parameter  int unsigned DEPTH  = 16,
   parameter  int unsigned DATA_W = 8,
   localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic [PTR_W:0]    count,
   output logic              full,
   output logic              empty
);

   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]    count_q, count_d;
   logic              wr_en, rd_en;

   always_comb begin
      rd_en = pop && (count_q != '0);
      // A simultaneous pop makes room, so a push at full still lands.
      wr_en = push && ((count_q != FULL_CNT) || rd_en);

      wr_ptr_d = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = rd_en ? rd_ptr_q + PTR_ONE : rd_ptr_q;

      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset so it can map onto RAM.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   assign dout  = mem_q[rd_ptr_q];
   assign count = count_q;
   assign full  = (count_q == FULL_CNT);
   assign empty = (count_q == '0);

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, LSB first) feeding a first-word-fall-through FIFO.
//   clk       : single clock, rising edge
//   rst       : synchronous active-high reset
//   rx_pin    : asynchronous serial input, idle high
//   ready     : FIFO not empty
//   ack       : pop one byte (ignored while ready is low)
//   data      : head-of-FIFO byte, valid while ready is high
//   count     : bytes stored, 0..DEPTH
//   frame_err : one-cycle pulse when a stop bit is sampled low
//   overrun   : sticky; a received byte was dropped because the FIFO was full
module uart_rx_fifo
   import uart_rx_fifo_pkg::*;
#(
   parameter  int unsigned BIT_PERIOD = UART_BIT_PERIOD,
   parameter  int unsigned DEPTH      = 16,
   localparam int unsigned CNT_W      = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rx_pin,
   output logic             ready,
   input  logic             ack,
   output logic [7:0]       data,
   output logic [CNT_W-1:0] count,
   output logic             frame_err,
   output logic             overrun
);

   localparam int unsigned   TMR_W     = $clog2(BIT_PERIOD);
   localparam logic [TMR_W-1:0] HALF_LAST = TMR_W'(BIT_PERIOD / 2 - 1);
   localparam logic [TMR_W-1:0] BIT_LAST  = TMR_W'(BIT_PERIOD - 1);
   localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);

   rx_state_e        state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             rx_meta_q, rx_meta_d;
   logic             rx_sync_q, rx_sync_d;
   logic             frame_err_q, frame_err_d;
   logic             overrun_q, overrun_d;
   logic             rx_push;
   logic             fifo_full, fifo_empty;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         tmr_q       <= '0;
         bit_idx_q   <= '0;
         rx_meta_q   <= 1'b1;
         rx_sync_q   <= 1'b1;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         tmr_q       <= tmr_d;
         bit_idx_q   <= bit_idx_d;
         rx_meta_q   <= rx_meta_d;
         rx_sync_q   <= rx_sync_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   always_ff @(posedge clk) begin
      shift_q <= shift_d;
   end

   // Next-state logic
   always_comb begin
      rx_meta_d = rx_pin;
      rx_sync_d = rx_meta_q;
      state_d   = state_q;
      tmr_d     = tmr_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;

      case (state_q)
         IDLE: begin
            if (!rx_sync_q) begin
               state_d   = START;
               tmr_d     = '0;
               bit_idx_d = '0;
            end
         end
         START: begin
            // Re-check mid start bit so short glitches are rejected.
            if (tmr_q == HALF_LAST) begin
               tmr_d   = '0;
               state_d = rx_sync_q ? IDLE : DATA;
            end else begin
               tmr_d = tmr_q + TMR_ONE;
            end
         end
         DATA: begin
            // Timer was aligned mid start bit, so each wrap lands mid bit.
            if (tmr_q == BIT_LAST) begin
               tmr_d     = '0;
               shift_d   = {rx_sync_q, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  state_d = STOP;
               end
            end else begin
               tmr_d = tmr_q + TMR_ONE;
            end
         end
         STOP: begin
            if (tmr_q == BIT_LAST) begin
               tmr_d   = '0;
               state_d = rx_sync_q ? IDLE : BREAK;
            end else begin
               tmr_d = tmr_q + TMR_ONE;
            end
         end
         BREAK: begin
            if (rx_sync_q) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      rx_push     = 1'b0;
      frame_err_d = 1'b0;
      if ((state_q == STOP) && (tmr_q == BIT_LAST)) begin
         rx_push     = rx_sync_q;
         frame_err_d = !rx_sync_q;
      end
      // A pop in the same cycle frees a slot, so that push is not a drop.
      overrun_d = overrun_q | (rx_push & fifo_full & ~ack);
   end

   sync_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (8)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rx_push),
      .pop   (ack),
      .din   (shift_q),
      .dout  (data),
      .count (count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign ready     = !fifo_empty;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

   localparam int BP    = 16;
   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_pin;
   logic       ack;
   logic       ready;
   logic [7:0] data;
   logic [4:0] count;
   logic       frame_err;
   logic       overrun;

   int n_vec  = 0;
   int n_err  = 0;
   int fe_cnt = 0;

   logic [7:0] exp_q[$];
   logic       exp_ovr;

   uart_rx_fifo #(
      .BIT_PERIOD (BP),
      .DEPTH      (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_pin    (rx_pin),
      .ready     (ready),
      .ack       (ack),
      .data      (data),
      .count     (count),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_err === 1'b1) fe_cnt++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Serial frame: start, 8 data bits LSB first, stop; line is left at stop value.
   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx_pin = 1'b0;
      repeat (BP) tick();
      for (int i = 0; i < 8; i++) begin
         rx_pin = b[i];
         repeat (BP) tick();
      end
      rx_pin = stop_bit;
      repeat (BP) tick();
   endtask

   task automatic model_rx(input logic [7:0] b);
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else exp_ovr = 1'b1;
   endtask

   task automatic send_good(input logic [7:0] b);
      send_byte(b, 1'b1);
      model_rx(b);
   endtask

   task automatic pop_one();
      ack = 1'b1;
      tick();
      ack = 1'b0;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      rx_pin = 1'b1;
      ack    = 1'b0;
      repeat (3) tick();
      exp_q.delete();
      exp_ovr = 1'b0;
      rst = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_reset();
      rst    = 1'b1;
      rx_pin = 1'b1;
      ack    = 1'b0;
      repeat (3) tick();
      n_vec++;
      if (ready !== 1'b0 || count !== 5'd0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
         n_err++;
         $display("FAIL reset_state: ready=%b count=%0d frame_err=%b overrun=%b, want 0/0/0/0",
                  ready, count, frame_err, overrun);
      end
      exp_q.delete();
      exp_ovr = 1'b0;
      rst = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_single();
      int n;
      n = 0;
      fork
         send_byte(8'h41, 1'b1);
         begin
            while (ready !== 1'b1 && n < 12 * BP) begin
               tick();
               n++;
            end
         end
      join
      model_rx(8'h41);
      n_vec++;
      if (n < (19 * BP) / 2 || n > (19 * BP) / 2 + 4) begin
         n_err++;
         $display("FAIL single_latency: ready after %0d clocks, want %0d..%0d",
                  n, (19 * BP) / 2, (19 * BP) / 2 + 4);
      end
      n_vec++;
      if (ready !== 1'b1 || data !== 8'h41 || count !== 5'(exp_q.size())) begin
         n_err++;
         $display("FAIL single_data: ready=%b data=%h count=%0d, want 1/41/%0d",
                  ready, data, count, exp_q.size());
      end
      pop_one();
      n_vec++;
      if (ready !== 1'b0 || count !== 5'd0) begin
         n_err++;
         $display("FAIL single_pop: ready=%b count=%0d, want 0/0", ready, count);
      end
   endtask

   task automatic test_glitch();
      int fe0;
      fe0 = fe_cnt;
      rx_pin = 1'b0;
      repeat (4) tick();
      rx_pin = 1'b1;
      repeat (2 * BP) tick();
      n_vec++;
      if (ready !== 1'b0 || count !== 5'd0 || fe_cnt != fe0) begin
         n_err++;
         $display("FAIL glitch: ready=%b count=%0d frame_errs=%0d, want 0/0/0",
                  ready, count, fe_cnt - fe0);
      end
   endtask

   task automatic test_frame_err();
      int fe0;
      fe0 = fe_cnt;
      send_byte(8'h55, 1'b0);
      repeat (3 * BP) tick();
      rx_pin = 1'b1;
      repeat (BP) tick();
      n_vec++;
      if (fe_cnt - fe0 != 1 || count !== 5'd0 || ready !== 1'b0) begin
         n_err++;
         $display("FAIL frame_err: pulses=%0d count=%0d ready=%b, want 1/0/0",
                  fe_cnt - fe0, count, ready);
      end
      send_good(8'h31);
      n_vec++;
      if (ready !== 1'b1 || data !== 8'h31 || count !== 5'd1) begin
         n_err++;
         $display("FAIL after_break: ready=%b data=%h count=%0d, want 1/31/1", ready, data, count);
      end
      pop_one();
   endtask

   task automatic test_overrun();
      logic [7:0] b;
      for (int i = 0; i <= 16; i++) send_good(8'(i));
      n_vec++;
      if (count !== 5'(exp_q.size()) || overrun !== exp_ovr) begin
         n_err++;
         $display("FAIL overrun_fill: count=%0d overrun=%b, want %0d/%b",
                  count, overrun, exp_q.size(), exp_ovr);
      end
      for (int i = 0; i < 16; i++) begin
         n_vec++;
         if (ready !== 1'b1 || data !== exp_q[0]) begin
            n_err++;
            $display("FAIL overrun_pop[%0d]: ready=%b data=%h, want 1/%h", i, ready, data, exp_q[0]);
         end
         pop_one();
      end
      n_vec++;
      if (ready !== 1'b0 || count !== 5'd0 || overrun !== 1'b1) begin
         n_err++;
         $display("FAIL overrun_drained: ready=%b count=%0d overrun=%b, want 0/0/1",
                  ready, count, overrun);
      end
      b = 8'($urandom);
      send_good(b);
      n_vec++;
      if (ready !== 1'b1 || data !== b) begin
         n_err++;
         $display("FAIL wrap_read: ready=%b data=%h, want 1/%h", ready, data, b);
      end
      pop_one();
      do_reset();
      n_vec++;
      if (overrun !== 1'b0) begin
         n_err++;
         $display("FAIL overrun_clear: overrun=%b, want 0", overrun);
      end
   endtask

   task automatic test_push_pop_full();
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) send_good(8'($urandom));
      fork
         send_byte(8'hAA, 1'b1);
         begin
            for (int i = 0; i < 12 * BP && !hit; i++) begin
               tick();
               if (dut.rx_push === 1'b1) begin
                  ack = 1'b1;
                  tick();
                  ack = 1'b0;
                  hit = 1'b1;
               end
            end
         end
      join
      if (hit) begin
         void'(exp_q.pop_front());
         exp_q.push_back(8'hAA);
      end
      n_vec++;
      if (!hit || count !== 5'd16 || overrun !== 1'b0) begin
         n_err++;
         $display("FAIL full_push_pop: seen=%b count=%0d overrun=%b, want 1/16/0", hit, count, overrun);
      end
      for (int i = 0; i < DEPTH; i++) begin
         n_vec++;
         if (ready !== 1'b1 || data !== exp_q[0]) begin
            n_err++;
            $display("FAIL full_drain[%0d]: ready=%b data=%h, want 1/%h", i, ready, data, exp_q[0]);
         end
         pop_one();
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] b;
      int fe0;
      b = 8'hC3;
      fe0 = fe_cnt;
      rx_pin = 1'b0;
      repeat (BP) tick();
      for (int i = 0; i < 4; i++) begin
         rx_pin = b[i];
         repeat (BP) tick();
      end
      rx_pin = b[4];
      repeat (BP / 2) tick();
      rst    = 1'b1;
      rx_pin = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      exp_q.delete();
      exp_ovr = 1'b0;
      repeat (2 * BP) tick();
      send_good(8'h7E);
      n_vec++;
      if (count !== 5'd1 || ready !== 1'b1 || data !== 8'h7E || fe_cnt != fe0 || overrun !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid: count=%0d ready=%b data=%h frame_errs=%0d overrun=%b, want 1/1/7e/0/0",
                  count, ready, data, fe_cnt - fe0, overrun);
      end
      pop_one();
   endtask

   task automatic test_random();
      logic [7:0] b;
      int k;
      for (int it = 0; it < 24; it++) begin
         b = 8'($urandom);
         send_good(b);
         k = $urandom_range(0, 2);
         for (int j = 0; j < k; j++) begin
            n_vec++;
            if (ready !== (exp_q.size() != 0) ||
                (exp_q.size() != 0 && data !== exp_q[0])) begin
               n_err++;
               $display("FAIL random_head[%0d]: ready=%b data=%h, want %b/%h",
                        it, ready, data, exp_q.size() != 0,
                        (exp_q.size() != 0) ? exp_q[0] : 8'h00);
            end
            pop_one();
         end
         n_vec++;
         if (count !== 5'(exp_q.size()) || overrun !== exp_ovr) begin
            n_err++;
            $display("FAIL random_count[%0d]: count=%0d overrun=%b, want %0d/%b",
                     it, count, overrun, exp_q.size(), exp_ovr);
         end
      end
      // Drain with an extra ack while empty, which must be ignored.
      for (int j = 0; j <= DEPTH; j++) begin
         if (exp_q.size() != 0) begin
            n_vec++;
            if (data !== exp_q[0]) begin
               n_err++;
               $display("FAIL random_drain: data=%h, want %h", data, exp_q[0]);
            end
         end
         pop_one();
      end
      n_vec++;
      if (ready !== 1'b0 || count !== 5'd0) begin
         n_err++;
         $display("FAIL empty_ack: ready=%b count=%0d, want 0/0", ready, count);
      end
   endtask

   initial begin
      rst    = 1'b1;
      rx_pin = 1'b1;
      ack    = 1'b0;
      exp_ovr = 1'b0;
      test_reset();
      test_single();
      test_glitch();
      test_frame_err();
      test_overrun();
      test_push_pop_full();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
